serial_rx_queue: RTL
====================

// Module: serial_rx_queue
// PURPOSE
//  Parametrised single-clock successor to the deserialiser + queue pair: shifts a serial bit stream into DATA_W-bit words
//  and buffers them in a DEPTH-entry FIFO with explicit full/empty/overflow status.
//  Bit sampling uses an internal clock-enable divider; no derived clocks. Sits between the serial input pins and the consumer.
// PARAMETERS
//  DATA_W   8   word width in bits (>=2)
//  DEPTH    8   FIFO entries (power of two, >=2)
//  BIT_DIV  10  clock cycles per serial bit tick (>=1; 1 = every cycle)
// PORTS
//  clock         in   1                     system clock, all logic on rising edge
//  reset         in   1                     synchronous, active-high
//  data_serial   in   1                     serial data bit, MSB first
//  write_serial  in   1                     bit qualifier, sampled on bit tick
//  dequeue       in   1                     pop head word (ignored when empty)
//  data_out      out  DATA_W                FIFO head word (first-word fall-through)
//  empty         out  1                     FIFO empty
//  full          out  1                     FIFO full
//  fifo_len      out  $clog2(DEPTH+1)       entries stored, 0..DEPTH
//  status_busy   out  1                     partial word in shift register
//  overflow      out  1                     one-cycle pulse: completed word dropped (FIFO full)
//  drop_count    out  8                     only with SERIAL_RX_DROP_COUNT_EN
// BEHAVIOUR
//  Reset (synchronous, active-high): all counters, pointers, shift register cleared; data_out=0, empty=1, full=0,
//   fifo_len=0, status_busy=0, overflow=0, drop_count=0. Reset mid-word discards partial word and clears stored words.
//  Tick gen: div_cnt counts 0..BIT_DIV-1; bit_tick when div_cnt==BIT_DIV-1, then wraps to 0.
//  Deserialiser: on bit_tick && write_serial: shreg <= {shreg[DATA_W-2:0], data_serial}; bit_cnt++.
//   write_serial low on a tick: no shift, bit_cnt held (word may span gaps).
//   status_busy = (bit_cnt != 0).
//   When the DATA_W-th bit is shifted, bit_cnt wraps to 0 and word_done pulses that cycle with the full word.
//  Push: word_done registered into FIFO on the next edge (word visible at data_out 2 cycles after last-bit tick, if FIFO was empty).
//   push accepted if !full, or if full && dequeue in the same cycle (simultaneous pop frees slot; fifo_len unchanged).
//   push rejected otherwise: word dropped, overflow=1 for exactly one cycle, FIFO unchanged.
//  Pop: dequeue && !empty advances read pointer; dequeue while empty is a no-op, no error flag.
//  Simultaneous push+pop when not empty: len unchanged, both pointers advance. Push+pop when empty: push only.
//  Pointers $clog2(DEPTH)+1 bits; wrap naturally; full = MSB differ && LSBs equal; empty = pointers equal.
//  fifo_len = wr_ptr - rd_ptr (modulo pointer width); never exceeds DEPTH.
//  data_out = mem[rd_ptr] combinationally from registered storage; value undefined-but-stable while empty (holds last).
// CONFIGURATION
//  SERIAL_RX_DROP_COUNT_EN defined: drop_count port present; increments on every overflow pulse, saturates at 255,
//   cleared only by reset.
//  Not defined: drop_count port and counter absent; overflow pulse still generated.
// STRUCTURE
//  Package serial_rx_pkg: DATA_W/DEPTH defaults, DROP_CNT_W=8, function len_width(depth) = $clog2(depth+1).
//  One sub-module: serial_rx_fifo (sync FIFO: push/pop/data/full/empty/len), instantiated once;
//   tick divider and deserialiser stay in top level.
// TESTING
//  1. Reset, BIT_DIV=1, shift 8'hA5 MSB-first with write_serial=1 -> after 2 cycles: empty=0, fifo_len=1, data_out=8'hA5.
//  2. BIT_DIV=10, write_serial drops low for 3 ticks mid-word -> bits held, status_busy=1 throughout, word 8'h3C correct.
//  3. Push 8 words 0x01..0x08, then 9th word -> full=1, fifo_len=8, overflow pulses 1 cycle, drop_count=1 (macro on).
//  4. Full FIFO, 9th word completes on same cycle as dequeue -> no overflow, fifo_len stays 8, head becomes 0x02, tail 0x09.
//  5. Dequeue on empty 5 cycles -> fifo_len=0, empty=1, no flag; then 20 push/pop pairs -> pointer wrap, order preserved.
//  6. Assert reset after 4 bits of a word with 3 stored -> next cycle fifo_len=0, status_busy=0; next full word stored alone.

Source files
------------

// File: rtl/serial_rx_pkg.sv
// Shared defaults and helpers for the serial receive queue.
package serial_rx_pkg;

    localparam int DATA_W_DEF  = 8;
    localparam int DEPTH_DEF   = 8;
    localparam int BIT_DIV_DEF = 10;
    localparam int DROP_CNT_W  = 8;

    function automatic int len_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/serial_rx_fifo.sv
// Synchronous first-word fall-through FIFO with extra-MSB pointers.
module serial_rx_fifo
    import serial_rx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             head,
    output logic                          empty,
    output logic                          full,
    output logic [len_width(DEPTH)-1:0]   len,
    output logic                          push_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = len_width(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [PW-1:0]     w_diff;
    logic              w_pop_ok;
    logic              w_push_ok;

    // A pop on a full FIFO frees the slot the simultaneous push needs.
    assign w_pop_ok  = pop && !empty;
    assign w_push_ok = push && (!full || pop);
    assign push_drop = push && full && !pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_diff = r_wr_ptr - r_rd_ptr;
    assign len    = LW'(w_diff);
    assign head   = r_mem[r_rd_ptr[AW-1:0]];

    // Storage and pointer update.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push_ok) begin
                r_mem[r_wr_ptr[AW-1:0]] <= push_data;
                r_wr_ptr                <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_rx_queue.sv
// Serial-to-word deserialiser feeding a FIFO; bit sampling on an internal tick.
// Optional drop counter enabled by defining SERIAL_RX_DROP_COUNT_EN.
module serial_rx_queue
    import serial_rx_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int BIT_DIV = BIT_DIV_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          data_serial,
    input  logic                          write_serial,
    input  logic                          dequeue,
    output logic [DATA_W-1:0]             data_out,
    output logic                          empty,
    output logic                          full,
    output logic [len_width(DEPTH)-1:0]   fifo_len,
    output logic                          status_busy,
    output logic                          overflow
`ifdef SERIAL_RX_DROP_COUNT_EN
    ,
    output logic [DROP_CNT_W-1:0]         drop_count
`endif
);

    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int CNT_W = $clog2(DATA_W);

    logic [DIV_W-1:0]  r_div_cnt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [DATA_W-1:0] r_shreg;
    logic              r_word_done;
    logic              r_overflow;
    logic              w_bit_tick;
    logic              w_shift;
    logic              w_last_bit;
    logic              w_push_drop;
    logic [DATA_W-1:0] w_shreg_next;

    assign w_bit_tick   = (r_div_cnt == DIV_W'(BIT_DIV - 1));
    assign w_shift      = w_bit_tick && write_serial;
    assign w_last_bit   = (r_bit_cnt == CNT_W'(DATA_W - 1));
    assign w_shreg_next = {r_shreg[DATA_W-2:0], data_serial};
    assign status_busy  = (r_bit_cnt != '0);
    assign overflow     = r_overflow;

    // Bit-tick divider.
    always_ff @(posedge clock) begin
        if (reset || w_bit_tick) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    // Shift register; the completed word stays in r_shreg during the push cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shreg     <= '0;
            r_bit_cnt   <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            if (w_shift) begin
                r_shreg <= w_shreg_next;
                if (w_last_bit) begin
                    r_bit_cnt   <= '0;
                    r_word_done <= 1'b1;
                end else begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Overflow pulse is registered on the edge that rejected the word.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push_drop;
        end
    end

`ifdef SERIAL_RX_DROP_COUNT_EN
    logic [DROP_CNT_W-1:0] r_drop_count;
    assign drop_count = r_drop_count;

    // Saturating count of dropped words.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_drop_count <= '0;
        end else if (w_push_drop && (r_drop_count != {DROP_CNT_W{1'b1}})) begin
            r_drop_count <= r_drop_count + DROP_CNT_W'(1);
        end
    end
`endif

    serial_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (r_word_done),
        .push_data (r_shreg),
        .pop       (dequeue),
        .head      (data_out),
        .empty     (empty),
        .full      (full),
        .len       (fifo_len),
        .push_drop (w_push_drop)
    );

endmodule
